// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the serial slice adder.
package adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder built from chained full adders.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);
  logic [SLICE:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[SLICE];
endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder: steps one SLICE-bit ripple adder over WIDTH-bit operands, LSB first.
// Optional feature macro ADD_SUB_EN adds a `sub` port for a-b-borrow_in.
module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int STEPS = WIDTH / SLICE;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t                        r_state;
  logic [SW-1:0]                 r_step;
  logic                          r_carry;
  logic [STEPS-1:0][SLICE-1:0]   r_a;
  logic [STEPS-1:0][SLICE-1:0]   r_b;
  logic [STEPS-1:0][SLICE-1:0]   r_sum;
  logic                          r_cout;
  logic                          r_out_valid;
  logic                          r_in_ready;
  logic                          r_busy;

  logic [SLICE-1:0]              w_slice_sum;
  logic                          w_slice_cout;
  logic                          w_sub;

`ifdef ADD_SUB_EN
  assign w_sub = sub;
`else
  assign w_sub = 1'b0;
`endif

  // Operands are held as slice arrays so the current step indexes its slice directly.
  adder_slice #(.SLICE(SLICE)) u_slice (
    .a    (r_a[r_step]),
    .b    (r_b[r_step]),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_step      <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            // Subtract folds into the add: a + ~b + ~cin.
            r_a        <= a;
            r_b        <= w_sub ? ~b : b;
            r_carry    <= cin ^ w_sub;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_step     <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[r_step] <= w_slice_sum;
          r_carry       <= w_slice_cout;
          if (r_step == SW'(STEPS - 1)) begin
            r_cout      <= w_slice_cout;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;
endmodule
